// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared state encoding, phase count and RTC register map
// for the RTC multiplexed-bus master.
package rtc_bus_pkg;

  localparam int NUM_PHASES = 7;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_ADDR_SETUP  = 3'd1;
  localparam state_t ST_ADDR_STROBE = 3'd2;
  localparam state_t ST_ADDR_HOLD   = 3'd3;
  localparam state_t ST_DATA_SETUP  = 3'd4;
  localparam state_t ST_DATA_STROBE = 3'd5;
  localparam state_t ST_DATA_HOLD   = 3'd6;
  localparam state_t ST_RECOVER     = 3'd7;

  localparam logic [7:0] RTC_ADDR_TIME  = 8'h21;
  localparam logic [7:0] RTC_ADDR_DATE  = 8'h24;
  localparam logic [7:0] RTC_ADDR_TIMER = 8'h27;

  typedef struct packed {
    logic       write;
    logic       burst;
    logic [7:0] addr;
    logic [7:0] wdata;
  } xact_t;

  function automatic logic is_addr_phase(input state_t s);
    return (s == ST_ADDR_SETUP) || (s == ST_ADDR_STROBE) || (s == ST_ADDR_HOLD);
  endfunction

  function automatic logic is_data_phase(input state_t s);
    return (s == ST_DATA_SETUP) || (s == ST_DATA_STROBE) || (s == ST_DATA_HOLD);
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// rtl/rtc_bus_ctrl_phase_timer.sv - counts PHASE_CYC cycles per bus phase and
// strobes phase_end_o on the last cycle of each phase.
module rtc_phase_timer #(
  parameter int PHASE_CYC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic phase_end_o
);

  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_end_o = run_i && (cnt_q == LAST);

  // Held at zero while idle so the first phase of a transaction is full length.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || phase_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - RTC multiplexed A/D bus master with host requests and
// double-buffered burst shadow file; RTC_BUS_AUTO_REFRESH_EN adds periodic bursts.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int         PHASE_CYC   = 10,
  parameter int         NUM_REGS    = 9,
  parameter logic [7:0] BURST_BASE  = 8'h21,
  parameter int         REFRESH_CYC = 10_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [7:0]            req_addr,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  input  logic                  burst_start,
  output logic                  burst_busy,
  output logic                  burst_done,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  A_D,
  output logic                  RD,
  output logic                  WR,
  output logic                  CS,
  output logic [7:0]            io_out,
  output logic                  io_oe,
  input  logic [7:0]            io_in
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  state_t state_q, state_d;
  xact_t  xact_q, xact_d;
  logic   phase_end;

  logic                     burst_busy_q;
  logic [IW-1:0]            burst_idx_q;
  logic [NUM_REGS-1:0][7:0] work_q;
  logic [NUM_REGS-1:0][7:0] regs_q;
  logic                     burst_done_q;
  logic [7:0]               cap_q;
  logic                     rsp_valid_q;
  logic [7:0]               rsp_rdata_q;

  logic idle, auto_req, burst_trig, burst_want, grant_host, grant_burst;
  logic capture, rsp_fire, burst_step_end;

  rtc_phase_timer #(
    .PHASE_CYC (PHASE_CYC)
  ) u_phase_timer (
    .clk         (clk),
    .rst_n       (reset),
    .run_i       (state_q != ST_IDLE),
    .phase_end_o (phase_end)
  );

`ifdef RTC_BUS_AUTO_REFRESH_EN
  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  logic [RW-1:0] refresh_q;
  logic          auto_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      auto_q    <= 1'b0;
    end else if (refresh_q == RW'(REFRESH_CYC - 1)) begin
      refresh_q <= '0;
      auto_q    <= 1'b1;
    end else begin
      refresh_q <= refresh_q + RW'(1);
      auto_q    <= 1'b0;
    end
  end

  assign auto_req = auto_q;
`else
  assign auto_req = 1'b0;
`endif

  assign idle       = (state_q == ST_IDLE);
  assign burst_trig = burst_start | auto_req;
  // A fresh trigger in IDLE is granted immediately so index 0 starts without delay.
  assign burst_want  = burst_busy_q | burst_trig;
  assign grant_host  = idle && req_valid;
  assign grant_burst = idle && !req_valid && burst_want;
  assign req_ready   = reset && idle && !grant_burst;

  assign capture        = (state_q == ST_DATA_STROBE) && phase_end && !xact_q.write;
  assign rsp_fire       = (state_q == ST_DATA_HOLD) && phase_end && !xact_q.burst;
  assign burst_step_end = (state_q == ST_RECOVER) && phase_end && xact_q.burst;

  always_comb begin
    state_d = state_q;
    xact_d  = xact_q;
    if (idle) begin
      if (grant_host) begin
        state_d = ST_ADDR_SETUP;
        xact_d  = '{write: req_write, burst: 1'b0, addr: req_addr, wdata: req_wdata};
      end else if (grant_burst) begin
        state_d = ST_ADDR_SETUP;
        xact_d  = '{write: 1'b0, burst: 1'b1, addr: BURST_BASE + 8'(burst_idx_q),
                    wdata: 8'h00};
      end
    end else if (phase_end) begin
      state_d = (state_q == ST_RECOVER) ? ST_IDLE : state_t'(state_q + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      xact_q  <= '0;
    end else begin
      state_q <= state_d;
      xact_q  <= xact_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q       <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      rsp_valid_q <= rsp_fire;
      if (capture && !xact_q.burst) begin
        cap_q <= io_in;
      end
      if (rsp_fire && !xact_q.write) begin
        rsp_rdata_q <= cap_q;
      end
    end
  end

  // burst_idx_q only moves at the end of a burst step, so it names the read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_busy_q <= 1'b0;
      burst_idx_q  <= '0;
      work_q       <= '0;
      regs_q       <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      if (burst_trig && !burst_busy_q) begin
        burst_busy_q <= 1'b1;
      end
      if (capture && xact_q.burst) begin
        work_q[burst_idx_q] <= io_in;
      end
      if (burst_step_end) begin
        if (burst_idx_q == LAST_IDX) begin
          regs_q       <= work_q;
          burst_done_q <= 1'b1;
          burst_busy_q <= 1'b0;
          burst_idx_q  <= '0;
        end else begin
          burst_idx_q <= burst_idx_q + IW'(1);
        end
      end
    end
  end

  // Strobes decode straight from state so an asynchronous reset frees the bus at once.
  always_comb begin
    CS     = !(is_addr_phase(state_q) || is_data_phase(state_q));
    A_D    = !is_addr_phase(state_q);
    WR     = !((state_q == ST_ADDR_STROBE) || ((state_q == ST_DATA_STROBE) && xact_q.write));
    RD     = !((state_q == ST_DATA_STROBE) && !xact_q.write);
    io_oe  = is_addr_phase(state_q) || (is_data_phase(state_q) && xact_q.write);
    io_out = 8'h00;
    if (is_addr_phase(state_q)) begin
      io_out = xact_q.addr;
    end else if (is_data_phase(state_q) && xact_q.write) begin
      io_out = xact_q.wdata;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign burst_busy = burst_busy_q;
  assign burst_done = burst_done_q;
  assign regs_flat  = regs_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - self-checking bench for rtc_bus_ctrl with an RTC bus
// model, response scoreboard and per-cycle strobe trace checks.
module tb_rtc_bus_ctrl;
  import rtc_bus_pkg::*;

  localparam int P     = 2;
  localparam int N     = 3;
  localparam int RCYC  = 200;
  localparam int XCYC  = NUM_PHASES * P;
  localparam int STEP  = XCYC + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid, req_ready, req_write;
  logic [7:0]      req_addr, req_wdata;
  logic            rsp_valid;
  logic [7:0]      rsp_rdata;
  logic            burst_start, burst_busy, burst_done;
  logic [8*N-1:0]  regs_flat;
  logic            A_D, RD, WR, CS, io_oe;
  logic [7:0]      io_out, io_in;

  rtc_bus_ctrl #(
    .PHASE_CYC   (P),
    .NUM_REGS    (N),
    .BURST_BASE  (8'h21),
    .REFRESH_CYC (RCYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .burst_start (burst_start),
    .burst_busy  (burst_busy),
    .burst_done  (burst_done),
    .regs_flat   (regs_flat),
    .A_D         (A_D),
    .RD          (RD),
    .WR          (WR),
    .CS          (CS),
    .io_out      (io_out),
    .io_oe       (io_oe),
    .io_in       (io_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RTC chip model: address latched on WR low in the address phase.
  logic [7:0] mem [256];
  logic [7:0] lat_addr = 8'h00;
  always @(posedge clk) begin
    if (!CS && !A_D && !WR) lat_addr = io_out;
    if (!CS && A_D && !WR && io_oe) mem[lat_addr] = io_out;
  end
  assign io_in = (!CS && !RD) ? mem[lat_addr] : 8'hEE;

  typedef struct {
    int         cyc;
    logic       rd;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_cycle", cyc, mon_e.cyc);
        if (mon_e.rd) chk("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, mon_e.data});
      end
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (reset && burst_done) done_cnt++;

  function automatic logic [12:0] exp_bus(input int k, input logic w,
                                          input logic [7:0] a, input logic [7:0] d);
    int ph;
    logic cs_e, rd_e, wr_e, ad_e, oe_e;
    logic [7:0] out_e;
    ph    = k / P;
    cs_e  = (ph >= 6);
    ad_e  = (ph >= 3);
    wr_e  = !((ph == 1) || ((ph == 4) && w));
    rd_e  = !((ph == 4) && !w);
    oe_e  = (ph < 3) || ((ph < 6) && w);
    out_e = !oe_e ? 8'h00 : ((ph < 3) ? a : d);
    return {cs_e, rd_e, wr_e, ad_e, oe_e, out_e};
  endfunction

  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input logic chk_ready, output int t_acc);
    exp_t e;
    logic ok;
    ok = 1'b0;
    t_acc = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    e.cyc = t_acc + 1 + 6 * P; e.rd = !w; e.data = exp_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < XCYC; k++) begin
      @(negedge clk);
      chk(w ? "wr_bus_trace" : "rd_bus_trace",
          {19'h0, CS, RD, WR, A_D, io_oe, (io_oe ? io_out : 8'h00)},
          {19'h0, exp_bus(k, w, a, d)});
    end
    if (chk_ready) begin
      @(negedge clk);
      chk("ready_after_xact", {31'h0, req_ready}, 32'd1);
    end
  endtask

  task automatic pulse_burst(output int s);
    @(posedge clk); #1;
    burst_start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    burst_start = 1'b0;
  endtask

  task automatic wait_done(output int at, output logic nz);
    at = -1;
    nz = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (burst_done) begin at = cyc; break; end
      if (regs_flat != '0) nz = 1'b1;
    end
    if (at < 0) chk("burst_done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t tv [9];

  int   t, s, s2, at, at2, d0;
  logic nz;

  initial begin
    tv[0] = '{1'b1, 8'h30, 8'hA5, 8'h00};
    tv[1] = '{1'b0, 8'h30, 8'h00, 8'hA5};
    tv[2] = '{1'b1, 8'h31, 8'h5A, 8'h00};
    tv[3] = '{1'b0, 8'h31, 8'h00, 8'h5A};
    tv[4] = '{1'b0, 8'h23, 8'h00, 8'h12};
    tv[5] = '{1'b1, 8'h00, 8'hFF, 8'h00};
    tv[6] = '{1'b0, 8'h00, 8'h00, 8'hFF};
    tv[7] = '{1'b1, 8'hFF, 8'h01, 8'h00};
    tv[8] = '{1'b0, 8'hFF, 8'h00, 8'h01};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
    req_wdata = 8'h00; burst_start = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_strobes", {28'h0, CS, RD, WR, A_D}, 32'hF);
    chk("rst_io_oe", {31'h0, io_oe}, 32'd0);
    chk("rst_io_out", {24'h0, io_out}, 32'd0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
    chk("rst_rsp", {23'h0, rsp_valid, rsp_rdata}, 32'd0);
    chk("rst_burst_flags", {30'h0, burst_busy, burst_done}, 32'd0);
    chk("rst_regs_flat", {8'h0, regs_flat}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, req_ready}, 32'd1);

`ifdef RTC_BUS_AUTO_REFRESH_EN
    d0 = done_cnt;
    wait_done(at, nz);
    chk("auto_regs", {8'h0, regs_flat}, {8'h0, mem[8'h23], mem[8'h22], mem[8'h21]});
    wait_done(at2, nz);
    chk("auto_period1", at2 - at, RCYC);
    wait_done(at, nz);
    chk("auto_period2", at - at2, RCYC);
    chk("auto_done_count", done_cnt - d0, 32'd3);
`else
    do_req(1'b1, 8'h22, 8'h45, 8'h00, 1'b1, t);
    chk("wr22_mem", {24'h0, mem[8'h22]}, 32'h45);

    mem[8'h23] = 8'h12;
    for (int i = 0; i < 9; i++) begin
      do_req(tv[i].w, tv[i].a, tv[i].d, tv[i].exp, 1'b1, t);
    end

    // Full burst with a redundant burst_start while busy.
    mem[8'h21] = 8'h11; mem[8'h22] = 8'h22; mem[8'h23] = 8'h33;
    d0 = done_cnt;
    pulse_burst(s);
    @(negedge clk);
    chk("burst_busy_set", {31'h0, burst_busy}, 32'd1);
    pulse_burst(s2);
    wait_done(at, nz);
    chk("burst_done_cycle", at, s + N * STEP);
    chk("burst_regs", {8'h0, regs_flat}, 32'h00332211);
    chk("burst_no_partial", {31'h0, nz}, 32'd0);
    repeat (60) @(negedge clk);
    chk("burst_done_once", done_cnt - d0, 32'd1);
    chk("burst_busy_clear", {31'h0, burst_busy}, 32'd0);

    // Host read interleaved after burst index 0.
    mem[8'h21] = 8'h44; mem[8'h22] = 8'h55; mem[8'h23] = 8'h66; mem[8'h40] = 8'h77;
    pulse_burst(s);
    do_req(1'b0, 8'h40, 8'h00, 8'h77, 1'b0, t);
    chk("mid_host_accept", t, s + STEP);
    wait_done(at, nz);
    chk("mid_done_cycle", at, s + N * STEP + STEP);
    chk("mid_regs", {8'h0, regs_flat}, 32'h00665544);

    // Reset during DATA_STROBE of a host write issued mid-burst.
    pulse_burst(s);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h50; req_wdata = 8'h99;
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin t = cyc; break; end
    end
    chk("rst_test_accept", t, s + STEP);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cyc == t + 1 + 4 * P) break;
      @(negedge clk);
    end
    chk("pre_rst_wr_low", {30'h0, WR, burst_busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_bus", {29'h0, WR, CS, io_oe}, 32'b110);
    chk("async_rst_regs", {7'h0, burst_busy, regs_flat}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_state", {29'h0, burst_busy, req_ready, rsp_valid}, 32'b010);
    chk("post_rst_regs", {8'h0, regs_flat}, 32'd0);

    d0 = done_cnt;
    repeat (300) @(negedge clk);
    chk("no_auto_burst", done_cnt - d0, 32'd0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
